// File: rtl/card_deal_bank.sv
// card_deal_bank: free-running 1..DECK_MAX card generator, six latched hand slots
// and mod-SCORE_MOD Baccarat scores for the player and dealer hands.
module card_deal_bank #(
    parameter int DECK_MAX  = 13,
    parameter int SCORE_MOD = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_hand,
    input  logic       deal_req,
    input  logic [2:0] deal_slot,
    output logic       deal_ack,
    output logic       deal_err,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore
);
    logic [3:0] gen;
    logic [3:0] slot [6];
    logic [7:0] occ;
    logic       take;
    logic [4:0] psum, dsum;

    function automatic logic [4:0] val(input logic [3:0] c);
        return c <= 4'd9 ? {1'b0, c} : 5'd0;
    endfunction

    // illegal slots 6/7 look permanently occupied so they always reject
    assign occ  = {2'b11, slot[5] != 0, slot[4] != 0, slot[3] != 0,
                   slot[2] != 0, slot[1] != 0, slot[0] != 0};
    assign take = deal_req && !new_hand;

    always_ff @(posedge clk) begin
        if (reset) begin
            gen      <= 4'd1;
            deal_ack <= 1'b0;
            deal_err <= 1'b0;
            for (int i = 0; i < 6; i++) slot[i] <= 4'd0;
        end else begin
            gen      <= gen == 4'(DECK_MAX) ? 4'd1 : gen + 4'd1;
            deal_ack <= take && !occ[deal_slot];
            deal_err <= take && occ[deal_slot];
            for (int i = 0; i < 6; i++)
                if (new_hand) slot[i] <= 4'd0;
                else if (take && !occ[deal_slot] && deal_slot == 3'(i)) slot[i] <= gen;
        end
    end

    assign psum   = val(slot[0]) + val(slot[1]) + val(slot[2]);
    assign dsum   = val(slot[3]) + val(slot[4]) + val(slot[5]);
    assign pscore = 4'(psum % 5'(SCORE_MOD));
    assign dscore = 4'(dsum % 5'(SCORE_MOD));
    assign pcard1 = slot[0];
    assign pcard2 = slot[1];
    assign pcard3 = slot[2];
    assign dcard1 = slot[3];
    assign dcard2 = slot[4];
    assign dcard3 = slot[5];
endmodule

// File: tb/tb_card_deal_bank.sv
// tb_card_deal_bank: directed scenarios plus random traffic against a
// cycle-count based model of the dealing bank.
module tb_card_deal_bank;
    logic       clk = 1'b0;
    logic       reset, new_hand, deal_req;
    logic [2:0] deal_slot;
    logic       deal_ack, deal_err;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;

    card_deal_bank dut (
        .clk(clk), .reset(reset), .new_hand(new_hand), .deal_req(deal_req),
        .deal_slot(deal_slot), .deal_ack(deal_ack), .deal_err(deal_err),
        .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
        .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
        .pscore(pscore), .dscore(dscore)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n;
    int m [6];
    int eack, eerr;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int score(input int a, input int b, input int c);
        int s = 0;
        int v [3];
        v = '{a, b, c};
        foreach (v[i]) if (v[i] >= 1 && v[i] <= 9) s += v[i];
        return s % 10;
    endfunction

    task automatic check_all();
        chk("ack", deal_ack, eack);
        chk("err", deal_err, eerr);
        chk("pcard1", pcard1, m[0]);
        chk("pcard2", pcard2, m[1]);
        chk("pcard3", pcard3, m[2]);
        chk("dcard1", dcard1, m[3]);
        chk("dcard2", dcard2, m[4]);
        chk("dcard3", dcard3, m[5]);
        chk("pscore", pscore, score(m[0], m[1], m[2]));
        chk("dscore", dscore, score(m[3], m[4], m[5]));
    endtask

    // n counts edges since reset; cycle cN sees card (N mod 13)+1
    task automatic step(input bit r, input bit nh, input bit dr, input int ds);
        int card;
        reset = r; new_hand = nh; deal_req = dr; deal_slot = 3'(ds);
        @(posedge clk);
        eack = 0; eerr = 0;
        if (r) begin
            n = 0;
            foreach (m[i]) m[i] = 0;
        end else begin
            card = (n % 13) + 1;
            n++;
            if (nh) foreach (m[i]) m[i] = 0;
            else if (dr) begin
                if (ds <= 5 && m[ds] == 0) begin m[ds] = card; eack = 1; end
                else eerr = 1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; new_hand = 0; deal_req = 0; deal_slot = 0;
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("tp1_pcard1", pcard1, 1);
        chk("tp1_ack", deal_ack, 1);
        chk("tp1_pscore", pscore, 1);

        step(1, 0, 0, 0);
        idle(8);
        step(0, 0, 1, 3);
        step(0, 0, 1, 4);
        chk("tp2_dcard1", dcard1, 9);
        chk("tp2_dcard2", dcard2, 10);
        chk("tp2_dscore", dscore, 9);

        step(1, 0, 0, 0);
        idle(5);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        idle(4);
        step(0, 0, 1, 2);
        chk("tp3_pcard3", pcard3, 12);
        chk("tp3_pscore", pscore, 3);

        step(1, 0, 0, 0);
        idle(13);
        step(0, 0, 1, 0);
        chk("wrap_pcard1", pcard1, 1);
        step(0, 0, 1, 0);
        chk("occ_err", deal_err, 1);
        chk("occ_ack", deal_ack, 0);
        step(0, 0, 1, 7);
        chk("ill_err", deal_err, 1);

        step(0, 0, 1, 3);
        step(0, 0, 1, 2);
        step(0, 1, 1, 5);
        chk("nh_pscore", pscore, 0);
        chk("nh_dcard3", dcard3, 0);

        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 4);
        step(1, 0, 1, 2);
        chk("rst_pcard1", pcard1, 0);
        step(0, 0, 1, 5);
        chk("post_rst_dcard3", dcard3, 1);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(63) == 0, $urandom_range(15) == 0,
                 $urandom_range(1) == 1, int'($urandom_range(7)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
